// File: rtl/uart_fifo_pkg.sv
// Shared state encodings, parity helper and counter sizing for the UART/FIFO bridge.
// Latency: n/a (declarations only). Backpressure: n/a.
// Defining UART_FIFO_PARITY_EN adds an even-parity bit and an RX PARITY state.
package uart_fifo_pkg;

`ifdef UART_FIFO_PARITY_EN
  localparam int PAR_BITS = 1;
  localparam int RX_ST_W  = 3;
`else
  localparam int PAR_BITS = 0;
  localparam int RX_ST_W  = 2;
`endif

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [RX_ST_W-1:0] {
    RX_IDLE   = RX_ST_W'(ST_IDLE),
    RX_START  = RX_ST_W'(ST_START),
    RX_DATA   = RX_ST_W'(ST_DATA),
`ifdef UART_FIFO_PARITY_EN
    RX_PARITY = RX_ST_W'(4),
`endif
    RX_STOP   = RX_ST_W'(ST_STOP)
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = ST_IDLE,
    TX_START = ST_START,
    TX_DATA  = ST_DATA,
    TX_STOP  = ST_STOP
  } tx_state_t;

  // Width of a counter that runs 0 .. baud_div-1.
  function automatic int baud_cnt_w(input int baud_div);
    return (baud_div > 2) ? $clog2(baud_div) : 1;
  endfunction

  // Even parity over up to 9 data bits; zero-extension does not change the result.
  function automatic logic even_parity(input logic [8:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with registered read port and sticky overflow flag.
// Latency: pop at edge N presents rd_dat_o/rd_vld_o at edge N+1; push visible in count next edge.
// Backpressure: none upstream; pushes while full (without a same-cycle pop) are dropped.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_vld_i,
  input  logic [DATA_W-1:0] push_dat_i,
  input  logic              pop_vld_i,
  output logic [DATA_W-1:0] rd_dat_o,
  output logic              rd_vld_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              overflow_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] rd_dat_q, rd_dat_d;
  logic              rd_vld_q;
  logic              overflow_q, overflow_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_vld_i & ~empty_o;
  // A same-cycle pop frees a slot, so a full FIFO still accepts the push.
  assign do_push = push_vld_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_dat_d   = rd_dat_q;
    overflow_d = overflow_q | (push_vld_i & ~do_push);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      rd_dat_d = mem_q[rd_ptr_q];
    end
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_dat_q   <= '0;
      rd_vld_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_dat_q   <= rd_dat_d;
      rd_vld_q   <= do_pop;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign rd_dat_o   = rd_dat_q;
  assign rd_vld_o   = rd_vld_q;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_fifo_bridge.sv
// UART RX deserialiser into a sync FIFO, drained by host pops or a UART TX loopback engine.
// Latency: word enters FIFO 2 edges after the mid-stop-bit sample; host pop data 1 edge after rd_en.
// Backpressure: none on the serial line; words arriving at a full FIFO are dropped (sticky overflow).
// Optional: UART_FIFO_PARITY_EN adds even parity on RX and TX.
module uart_fifo_bridge import uart_fifo_pkg::*; #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int BAUD_DIV = 1350,
  parameter int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              tx,
  input  logic              loop_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              frame_err,
  output logic              parity_err,
  output logic              tx_busy
);
  localparam int BCW     = baud_cnt_w(BAUD_DIV);
  localparam int IDX_W   = 4;
  localparam int TX_BITS = DATA_W + PAR_BITS;
  localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
  localparam logic [BCW-1:0] BAUD_HALF = BCW'(BAUD_DIV / 2 - 1);
`ifdef UART_FIFO_PARITY_EN
  localparam rx_state_t RX_AFTER_DATA = RX_PARITY;
`else
  localparam rx_state_t RX_AFTER_DATA = RX_STOP;
`endif

  logic              fifo_pop, fifo_empty;
  logic [DATA_W-1:0] fifo_rd_dat;

  // Synchroniser resets low so a line held low through reset cannot look like a start edge.
  logic rx_meta_q, rx_sync_q, rx_prev_q, rx_fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b0;
      rx_sync_q <= 1'b0;
      rx_prev_q <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_sync_q;

  rx_state_t         rx_state_q;
  logic [BCW-1:0]    rx_cnt_q;
  logic [IDX_W-1:0]  rx_idx_q;
  logic [DATA_W-1:0] rx_shift_q;
  logic              rx_push_q;
  logic [DATA_W-1:0] rx_push_dat_q;
  logic              frame_err_q, parity_err_q, rx_par_ok;

`ifdef UART_FIFO_PARITY_EN
  logic rx_par_q;
  assign rx_par_ok = (rx_par_q == even_parity(9'(rx_shift_q)));
`else
  assign rx_par_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q    <= RX_IDLE;
      rx_cnt_q      <= '0;
      rx_idx_q      <= '0;
      rx_shift_q    <= '0;
      rx_push_q     <= 1'b0;
      rx_push_dat_q <= '0;
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
`ifdef UART_FIFO_PARITY_EN
      rx_par_q      <= 1'b0;
`endif
    end else begin
      rx_push_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          rx_cnt_q <= '0;
          if (rx_fall) rx_state_q <= RX_START;
        end
        RX_START: begin
          if (rx_cnt_q == BAUD_HALF) begin
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + BCW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == BAUD_LAST) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_W-1:1]};
            rx_idx_q   <= rx_idx_q + IDX_W'(1);
            if (rx_idx_q == IDX_W'(DATA_W - 1)) rx_state_q <= RX_AFTER_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + BCW'(1);
          end
        end
`ifdef UART_FIFO_PARITY_EN
        RX_PARITY: begin
          if (rx_cnt_q == BAUD_LAST) begin
            rx_cnt_q   <= '0;
            rx_par_q   <= rx_sync_q;
            rx_state_q <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + BCW'(1);
          end
        end
`endif
        RX_STOP: begin
          if (rx_cnt_q == BAUD_LAST) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_IDLE;
            // A bad stop bit masks a parity error on the same character.
            if (!rx_sync_q)      frame_err_q  <= 1'b1;
            else if (!rx_par_ok) parity_err_q <= 1'b1;
            else begin
              rx_push_q     <= 1'b1;
              rx_push_dat_q <= rx_shift_q;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + BCW'(1);
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  tx_state_t          tx_state_q;
  logic [BCW-1:0]     tx_cnt_q;
  logic [IDX_W-1:0]   tx_idx_q;
  logic [TX_BITS-1:0] tx_shift_q, tx_frame;
  logic               tx_q, tx_pop;

`ifdef UART_FIFO_PARITY_EN
  assign tx_frame = {even_parity(9'(fifo_rd_dat)), fifo_rd_dat};
`else
  assign tx_frame = fifo_rd_dat;
`endif

  assign tx_pop = (tx_state_q == TX_IDLE) & loop_en & ~fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          tx_cnt_q <= '0;
          if (tx_pop) begin
            tx_state_q <= TX_START;
            tx_q       <= 1'b0;
          end
        end
        TX_START: begin
          // The popped word lands on the FIFO read port on the START entry edge.
          if (tx_cnt_q == '0) tx_shift_q <= tx_frame;
          if (tx_cnt_q == BAUD_LAST) begin
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
            tx_state_q <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + BCW'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == BAUD_LAST) begin
            tx_cnt_q <= '0;
            if (tx_idx_q == IDX_W'(TX_BITS - 1)) begin
              tx_q       <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
              tx_idx_q   <= tx_idx_q + IDX_W'(1);
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + BCW'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt_q == BAUD_LAST) begin
            tx_cnt_q   <= '0;
            tx_state_q <= TX_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + BCW'(1);
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign fifo_pop = tx_pop | (rd_en & ~loop_en);

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_vld_i (rx_push_q),
    .push_dat_i (rx_push_dat_q),
    .pop_vld_i  (fifo_pop),
    .rd_dat_o   (fifo_rd_dat),
    .rd_vld_o   (rd_valid),
    .count_o    (count),
    .full_o     (full),
    .empty_o    (fifo_empty),
    .overflow_o (overflow)
  );

  assign rd_data    = fifo_rd_dat;
  assign empty      = fifo_empty;
  assign tx         = tx_q;
  assign tx_busy    = (tx_state_q != TX_IDLE);
  assign frame_err  = frame_err_q;
  // Without parity support this register never leaves zero.
  assign parity_err = parity_err_q;

endmodule

// File: doc/uart_fifo_bridge.md
Name: uart_fifo_bridge

Overview:
Parametrised successor to the camera UART/FIFO path. Deserialises bytes from a UART RX line into a synchronous FIFO of configurable width and depth. Bytes leave the FIFO by one of two routes: a host-side synchronous pop strobe, or an automatic loopback mode that drains the FIFO through a UART TX serialiser. The block sits between the camera/debug serial link and the capture logic, on a single clock domain.

Parameters:
DATA_W, 8, bits per UART character and FIFO word width (5..9)
DEPTH, 16, number of FIFO entries; must be a power of two, minimum 2
BAUD_DIV, 1350, clk cycles per bit period; must be at least 4
CNT_W, $clog2(DEPTH)+1, width of the occupancy count (derived; do not override)

Ports:
clk  in  1  system clock; all logic is on the rising edge
reset  in  1  synchronous, active-high reset
rx  in  1  UART receive line; asynchronous; idle level is high
tx  out  1  UART transmit line; idle level is high
loop_en  in  1  1 = the TX engine drains the FIFO automatically; 0 = host drains it with rd_en
rd_en  in  1  host pop strobe, one word per asserted cycle; ignored while loop_en=1
rd_data  out  DATA_W  popped word, registered
rd_valid  out  1  one-cycle pulse marking rd_data valid
count  out  CNT_W  current FIFO occupancy
full  out  1  count==DEPTH
empty  out  1  count==0
overflow  out  1  sticky flag: a received word was dropped because the FIFO was full
frame_err  out  1  one-cycle pulse: stop bit sampled low
parity_err  out  1  one-cycle pulse: parity mismatch (see Optional Feature)
tx_busy  out  1  TX engine is not in IDLE

Behaviour:
- Reset values: tx=1, rd_data=0, rd_valid=0, count=0, full=0, empty=1, overflow=0, frame_err=0, parity_err=0, tx_busy=0. Both FSMs go to IDLE, FIFO pointers clear, and any partial RX or TX character is discarded.
- RX input: rx passes through a 2-flop synchroniser. Only a falling edge of the synchronised signal arms the receiver, so a line held low across reset release is ignored until it returns high.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a falling edge.
  - START waits BAUD_DIV/2 cycles, then samples the line: low -> DATA; high -> IDLE (treated as a glitch).
  - DATA samples DATA_W bits, one every BAUD_DIV cycles, LSB first.
  - STOP samples once after BAUD_DIV cycles: high -> push the word into the FIFO; low -> pulse frame_err and drop the word. Both outcomes return to IDLE.
- FIFO push and pop:
  - A push while full drops the word and sets overflow; overflow stays set until reset.
  - A pop while empty is ignored: no rd_valid, and rd_data holds its value.
  - A push and a pop in the same cycle both take effect and count is unchanged. This also applies when full: the word is accepted and overflow is not set.
  - Pointers wrap modulo DEPTH.
- Host pop timing: rd_en=1 with empty=0 at edge N gives rd_data = head word and rd_valid=1 at edge N+1. count decrements at edge N+1.
- TX FSM states: IDLE, START, DATA, STOP; each bit lasts exactly BAUD_DIV cycles.
  - In IDLE with loop_en=1 and empty=0, pop one word and move to START on the next edge; tx goes low on that edge.
  - Bits are sent LSB first, followed by a single high stop bit, then IDLE.
  - Back-to-back words have no idle gap beyond the IDLE decision cycle.
  - Deasserting loop_en mid-character does not abort the character; it only stops further pops.
- The TX FSM never pops from the FIFO when loop_en=0.

Optional Feature:
UART_FIFO_PARITY_EN
- Defined: an even-parity bit is inserted after the data bits on both RX and TX. RX gains a PARITY state between DATA and STOP. If the parity bit mismatches, parity_err pulses for one cycle and the word is dropped. If both the parity and stop bits are bad, only frame_err is reported.
- Undefined: there is no parity bit and parity_err is tied to 0.

Decomposition:
- Package uart_fifo_pkg holds:
  - the RX and TX state encodings (2-bit localparams);
  - the parity helper function;
  - the baud-counter width derived from BAUD_DIV.
- Sub-module sync_fifo (DATA_W, DEPTH) implements the pointers, count, full/empty and the registered read port. The RX and TX FSMs stay in the top level.

Test Plan (BAUD_DIV=16, DATA_W=8, DEPTH=4):
- Host pop: send 0xA5 on rx with loop_en=0. Expect count=1 after the stop bit. Pulse rd_en: rd_data=0xA5 and rd_valid=1 on the next edge, then count=0 and empty=1.
- Overflow and ordering: send 5 bytes 0x01..0x05 with no pops. Expect full=1, overflow=1, count=4. Four pops return 0x01..0x04 in order.
- Loopback: loop_en=1, send 0x3C. tx must reproduce the frame: start bit low, bits 0,0,1,1,1,1,0,0 (LSB first), stop bit high, each bit 16 cycles wide. tx_busy is high throughout, and empty=1 afterwards.
- Frame error: send 0x55 with the stop bit forced low. Expect a single frame_err pulse, count=0, overflow=0.
- Glitch and reset: a 3-cycle low glitch on rx must not push a word. Asserting reset midway through a received character must leave count=0 and tx=1, and no push may occur after reset is released.
- Simultaneous push and pop at full: with the FIFO full, assert rd_en on the exact cycle the RX stop bit completes. Expect count to stay 4 and overflow=0.
